// File: rtl/lifo_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lifo_fifo_pkg
// Purpose  : Shared definitions for the lifo_fifo_ctrl block.
//            - run-time mode encodings
//            - occupancy state encoding
//            - pointer helpers that wrap at an arbitrary MEM_SIZE
// Revision : 1.0 - initial release
// ============================================================================
package lifo_fifo_pkg;

  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_LIFO = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  // Increment with wrap from size-1 back to 0 (size need not be a power of two).
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] size);
    return (ptr == size - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  // Decrement with wrap from 0 back to size-1.
  function automatic logic [31:0] ptr_dec(input logic [31:0] ptr, input logic [31:0] size);
    return (ptr == 32'd0) ? size - 32'd1 : ptr - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : lifo_fifo_ptr
// Purpose  : Address pointer register that wraps at MEM_SIZE.
// Ports    : clk, rst_i   - clock, synchronous active-high reset
//            clr_i        - synchronous clear to 0 (priority over inc/dec)
//            inc_i, dec_i - step up / down; both together hold the value
//            ptr_o        - current pointer value
// Revision : 1.0 - initial release
// ============================================================================
module lifo_fifo_ptr
  import lifo_fifo_pkg::*;
#(
  parameter int ADR_WIDTH = 11,
  parameter int MEM_SIZE  = 2048
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [ADR_WIDTH-1:0] ptr_o
);

  logic [ADR_WIDTH-1:0] ptr_d;
  logic [ADR_WIDTH-1:0] ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i && !dec_i) begin
      ptr_d = ADR_WIDTH'(ptr_inc(32'(ptr_q), 32'(MEM_SIZE)));
    end else if (dec_i && !inc_i) begin
      ptr_d = ADR_WIDTH'(ptr_dec(32'(ptr_q), 32'(MEM_SIZE)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/lifo_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lifo_fifo_ctrl
// Purpose  : Sequencing controller running a 1-cycle-read dual-port RAM as a
//            FIFO (mode 0) or LIFO (mode 1). Data flows directly between the
//            client and the RAM; this block only produces addresses, enables,
//            occupancy, flags and read-data-valid timing.
// Ports    : clk, rst_i            - clock, synchronous active-high reset
//            mode_i                - 0 FIFO / 1 LIFO, taken only while empty
//            flush_i               - synchronous clear (mode is kept)
//            push_i, pop_i         - client requests
//            ram_we_o, ram_rde_o   - RAM write / read enables
//            ram_adr_wr_o/_rd_o    - RAM addresses
//            dat_valid_o           - RAM dat_o holds popped data this cycle
//            count_o, full_o, empty_o, mode_o - status
//            ovf_o, udf_o          - sticky error flags
// Options  : LIFO_FIFO_ERR_EN - when defined, ovf_o/udf_o are implemented;
//            otherwise both are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module lifo_fifo_ctrl
  import lifo_fifo_pkg::*;
#(
  parameter int ADR_WIDTH = 11,
  parameter int MEM_SIZE  = 2048
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 mode_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  output logic                 ram_we_o,
  output logic                 ram_rde_o,
  output logic [ADR_WIDTH-1:0] ram_adr_wr_o,
  output logic [ADR_WIDTH-1:0] ram_adr_rd_o,
  output logic                 dat_valid_o,
  output logic [ADR_WIDTH:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 mode_o,
  output logic                 ovf_o,
  output logic                 udf_o
);

  localparam logic [ADR_WIDTH:0] CNT_MAX = (ADR_WIDTH+1)'(MEM_SIZE);

  occ_state_e           state_q, state_d;
  logic [ADR_WIDTH:0]   count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 mode_q, mode_d;
  logic                 valid_q, valid_d;

  logic                 push_acc, pop_acc;
  logic                 is_lifo;
  logic                 wr_inc, wr_dec, rd_inc, ptr_clr;
  logic [ADR_WIDTH-1:0] wr_ptr, rd_ptr, sp_m1;

  // Reset and flush win over client requests, so nothing reaches the RAM then.
  always_comb begin
    is_lifo  = (mode_q == MODE_LIFO);
    pop_acc  = pop_i & ~empty_q & ~flush_i & ~rst_i;
    push_acc = push_i & (~full_q | pop_acc) & ~flush_i & ~rst_i;
    // In LIFO the write instance is the stack pointer; a push/pop pair leaves it.
    wr_inc   = push_acc;
    wr_dec   = is_lifo & pop_acc;
    rd_inc   = ~is_lifo & pop_acc;
    // Pointers are re-zeroed whenever idle-empty so a mode change always starts
    // from a clean base (sp must equal count in LIFO).
    ptr_clr  = flush_i | ((state_q == ST_EMPTY) & ~push_acc);
  end

  lifo_fifo_ptr #(.ADR_WIDTH(ADR_WIDTH), .MEM_SIZE(MEM_SIZE)) u_wr_ptr (
    .clk   (clk),
    .rst_i (rst_i),
    .clr_i (ptr_clr),
    .inc_i (wr_inc),
    .dec_i (wr_dec),
    .ptr_o (wr_ptr)
  );

  lifo_fifo_ptr #(.ADR_WIDTH(ADR_WIDTH), .MEM_SIZE(MEM_SIZE)) u_rd_ptr (
    .clk   (clk),
    .rst_i (rst_i),
    .clr_i (ptr_clr),
    .inc_i (rd_inc),
    .dec_i (1'b0),
    .ptr_o (rd_ptr)
  );

  // sp holds count modulo MEM_SIZE, so sp-1 with wrap is the top entry even
  // when the stack is completely full (sp has wrapped to 0).
  assign sp_m1 = ADR_WIDTH'(ptr_dec(32'(wr_ptr), 32'(MEM_SIZE)));

  always_comb begin
    ram_we_o  = push_acc;
    ram_rde_o = pop_acc;
    if (is_lifo) begin
      ram_adr_wr_o = (push_acc && pop_acc) ? sp_m1 : wr_ptr;
      ram_adr_rd_o = (state_q == ST_EMPTY) ? '0 : sp_m1;
    end else begin
      ram_adr_wr_o = wr_ptr;
      ram_adr_rd_o = rd_ptr;
    end
  end

  // Occupancy FSM next-state; flags are derived from the next state.
  always_comb begin
    count_d = count_q;
    mode_d  = mode_q;
    valid_d = pop_acc;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (push_acc && !pop_acc) begin
        count_d = count_q + (ADR_WIDTH+1)'(1);
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - (ADR_WIDTH+1)'(1);
      end
      if ((state_q == ST_EMPTY) && !push_acc) begin
        mode_d = mode_i;
      end
    end
    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == CNT_MAX) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PART;
    end
    full_d  = (state_d == ST_FULL);
    empty_d = (state_d == ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      mode_q  <= MODE_FIFO;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
    end
  end

  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign mode_o      = mode_q;
  assign dat_valid_o = valid_q;

`ifdef LIFO_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (flush_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (push_i && full_q && !pop_acc) ovf_d = 1'b1;
      if (pop_i && empty_q) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lifo_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lifo_fifo_ctrl
// Purpose  : Directed, table-driven bench for lifo_fifo_ctrl (MEM_SIZE=4,
//            ADR_WIDTH=2) with a behavioural 1-cycle-read RAM attached.
//            Error-flag expectations follow LIFO_FIFO_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lifo_fifo_ctrl;

  localparam int ADR_WIDTH = 2;
  localparam int MEM_SIZE  = 4;
`ifdef LIFO_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_i, mode_i, flush_i, push_i, pop_i;
  logic                 ram_we, ram_rde, dat_valid, full, empty, mode_o, ovf, udf;
  logic [ADR_WIDTH-1:0] adr_wr, adr_rd;
  logic [ADR_WIDTH:0]   count;
  logic [7:0]           din, dout;
  logic [7:0]           mem [MEM_SIZE];

  always #5 clk = ~clk;

  lifo_fifo_ctrl #(.ADR_WIDTH(ADR_WIDTH), .MEM_SIZE(MEM_SIZE)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .mode_i       (mode_i),
    .flush_i      (flush_i),
    .push_i       (push_i),
    .pop_i        (pop_i),
    .ram_we_o     (ram_we),
    .ram_rde_o    (ram_rde),
    .ram_adr_wr_o (adr_wr),
    .ram_adr_rd_o (adr_rd),
    .dat_valid_o  (dat_valid),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .mode_o       (mode_o),
    .ovf_o        (ovf),
    .udf_o        (udf)
  );

  // RAM: registered read, old data returned on a same-address collision.
  always_ff @(posedge clk) begin
    if (ram_rde) dout <= mem[adr_rd];
    if (ram_we)  mem[adr_wr] <= din;
  end

  typedef struct {
    bit       mi, fl, pu, po;
    bit [7:0] d;
    bit       we, rde, ca;
    int       awr, ard, cnt;
    bit       ful, emp, mo, val;
    bit [7:0] dout;
    bit       ovf, udf;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(bit mi, bit fl, bit pu, bit po, bit [7:0] d,
                             bit we, bit rde, bit ca, int awr, int ard, int cnt,
                             bit ful, bit emp, bit mo, bit val, bit [7:0] dq,
                             bit ov, bit ud);
    vec_t r;
    r.mi = mi; r.fl = fl; r.pu = pu; r.po = po; r.d = d;
    r.we = we; r.rde = rde; r.ca = ca; r.awr = awr; r.ard = ard; r.cnt = cnt;
    r.ful = ful; r.emp = emp; r.mo = mo; r.val = val; r.dout = dq;
    r.ovf = ov; r.udf = ud;
    return r;
  endfunction

  task automatic chk(input int row, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  task automatic run(input int row, input vec_t t);
    mode_i = t.mi; flush_i = t.fl; push_i = t.pu; pop_i = t.po; din = t.d;
    #3;
    chk(row, "ram_we",  32'(ram_we),  32'(t.we));
    chk(row, "ram_rde", 32'(ram_rde), 32'(t.rde));
    if (t.ca) begin
      chk(row, "adr_wr", 32'(adr_wr), 32'(t.awr));
      chk(row, "adr_rd", 32'(adr_rd), 32'(t.ard));
    end
    @(posedge clk); #1;
    chk(row, "count", 32'(count), 32'(t.cnt));
    chk(row, "full",  32'(full),  32'(t.ful));
    chk(row, "empty", 32'(empty), 32'(t.emp));
    chk(row, "mode",  32'(mode_o), 32'(t.mo));
    chk(row, "valid", 32'(dat_valid), 32'(t.val));
    if (t.val) chk(row, "dout", 32'(dout), 32'(t.dout));
    chk(row, "ovf", 32'(ovf), 32'(t.ovf & ERR));
    chk(row, "udf", 32'(udf), 32'(t.udf & ERR));
  endtask

  initial begin
    //           mi fl pu po d      we rde ca awr ard cnt ful emp mo val dout   ovf udf
    // FIFO order
    tbl.push_back(v(0,0,1,0,8'h0A, 1,0,1,0,0, 1, 0,0,0,0,8'h00, 0,0));
    tbl.push_back(v(0,0,1,0,8'h0B, 1,0,1,1,0, 2, 0,0,0,0,8'h00, 0,0));
    tbl.push_back(v(0,0,1,0,8'h0C, 1,0,1,2,0, 3, 0,0,0,0,8'h00, 0,0));
    tbl.push_back(v(0,0,0,1,8'h00, 0,1,1,3,0, 2, 0,0,0,1,8'h0A, 0,0));
    tbl.push_back(v(0,0,0,1,8'h00, 0,1,1,3,1, 1, 0,0,0,1,8'h0B, 0,0));
    tbl.push_back(v(0,0,0,1,8'h00, 0,1,1,3,2, 0, 0,1,0,1,8'h0C, 0,0));
    // switch to LIFO while empty, then LIFO order
    tbl.push_back(v(1,0,0,0,8'h00, 0,0,1,3,3, 0, 0,1,1,0,8'h00, 0,0));
    tbl.push_back(v(1,0,1,0,8'h01, 1,0,1,0,0, 1, 0,0,1,0,8'h00, 0,0));
    tbl.push_back(v(1,0,1,0,8'h02, 1,0,1,1,0, 2, 0,0,1,0,8'h00, 0,0));
    tbl.push_back(v(1,0,1,0,8'h03, 1,0,1,2,1, 3, 0,0,1,0,8'h00, 0,0));
    tbl.push_back(v(1,0,0,1,8'h00, 0,1,1,3,2, 2, 0,0,1,1,8'h03, 0,0));
    tbl.push_back(v(1,0,0,1,8'h00, 0,1,1,2,1, 1, 0,0,1,1,8'h02, 0,0));
    tbl.push_back(v(1,0,0,1,8'h00, 0,1,1,1,0, 0, 0,1,1,1,8'h01, 0,0));
    tbl.push_back(v(0,0,0,0,8'h00, 0,0,0,0,0, 0, 0,1,0,0,8'h00, 0,0));
    // FIFO fill to full, fifth push dropped
    tbl.push_back(v(0,0,1,0,8'h10, 1,0,1,0,0, 1, 0,0,0,0,8'h00, 0,0));
    tbl.push_back(v(0,0,1,0,8'h11, 1,0,1,1,0, 2, 0,0,0,0,8'h00, 0,0));
    tbl.push_back(v(0,0,1,0,8'h12, 1,0,1,2,0, 3, 0,0,0,0,8'h00, 0,0));
    tbl.push_back(v(0,0,1,0,8'h13, 1,0,1,3,0, 4, 1,0,0,0,8'h00, 0,0));
    tbl.push_back(v(0,0,1,0,8'h14, 0,0,1,0,0, 4, 1,0,0,0,8'h00, 1,0));
    // full: push+pop together six times, pointers wrap 3->0
    tbl.push_back(v(0,0,1,1,8'h20, 1,1,1,0,0, 4, 1,0,0,1,8'h10, 1,0));
    tbl.push_back(v(0,0,1,1,8'h21, 1,1,1,1,1, 4, 1,0,0,1,8'h11, 1,0));
    tbl.push_back(v(0,0,1,1,8'h22, 1,1,1,2,2, 4, 1,0,0,1,8'h12, 1,0));
    tbl.push_back(v(0,0,1,1,8'h23, 1,1,1,3,3, 4, 1,0,0,1,8'h13, 1,0));
    tbl.push_back(v(0,0,1,1,8'h24, 1,1,1,0,0, 4, 1,0,0,1,8'h20, 1,0));
    tbl.push_back(v(0,0,1,1,8'h25, 1,1,1,1,1, 4, 1,0,0,1,8'h21, 1,0));
    tbl.push_back(v(0,0,0,1,8'h00, 0,1,1,2,2, 3, 0,0,0,1,8'h22, 1,0));
    tbl.push_back(v(0,0,0,1,8'h00, 0,1,1,2,3, 2, 0,0,0,1,8'h23, 1,0));
    tbl.push_back(v(0,0,0,1,8'h00, 0,1,1,2,0, 1, 0,0,0,1,8'h24, 1,0));
    tbl.push_back(v(0,0,0,1,8'h00, 0,1,1,2,1, 0, 0,1,0,1,8'h25, 1,0));
    // LIFO replace: 5,6 then push 7 with pop
    tbl.push_back(v(1,0,0,0,8'h00, 0,0,0,0,0, 0, 0,1,1,0,8'h00, 1,0));
    tbl.push_back(v(1,0,1,0,8'h05, 1,0,1,0,0, 1, 0,0,1,0,8'h00, 1,0));
    tbl.push_back(v(1,0,1,0,8'h06, 1,0,1,1,0, 2, 0,0,1,0,8'h00, 1,0));
    tbl.push_back(v(1,0,1,1,8'h07, 1,1,1,1,1, 2, 0,0,1,1,8'h06, 1,0));
    tbl.push_back(v(1,0,0,1,8'h00, 0,1,1,2,1, 1, 0,0,1,1,8'h07, 1,0));
    tbl.push_back(v(1,0,0,1,8'h00, 0,1,1,1,0, 0, 0,1,1,1,8'h05, 1,0));
    // underflow, mode change ignored when not empty, flush
    tbl.push_back(v(1,0,0,1,8'h00, 0,0,1,0,0, 0, 0,1,1,0,8'h00, 1,1));
    tbl.push_back(v(1,0,1,0,8'h08, 1,0,1,0,0, 1, 0,0,1,0,8'h00, 1,1));
    tbl.push_back(v(1,0,1,0,8'h09, 1,0,1,1,0, 2, 0,0,1,0,8'h00, 1,1));
    tbl.push_back(v(0,0,0,0,8'h00, 0,0,1,2,1, 2, 0,0,1,0,8'h00, 1,1));
    tbl.push_back(v(0,1,0,0,8'h00, 0,0,0,0,0, 0, 0,1,1,0,8'h00, 0,0));
    tbl.push_back(v(0,0,0,0,8'h00, 0,0,1,0,0, 0, 0,1,0,0,8'h00, 0,0));
    tbl.push_back(v(0,0,1,0,8'h33, 1,0,1,0,0, 1, 0,0,0,0,8'h00, 0,0));
    tbl.push_back(v(0,0,0,1,8'h00, 0,1,1,1,0, 0, 0,1,0,1,8'h33, 0,0));

    // Reset, with requests asserted to show reset priority.
    rst_i = 1'b1; mode_i = 1'b1; flush_i = 1'b0; push_i = 1'b1; pop_i = 1'b1; din = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk(-1, "rst_we",    32'(ram_we),    32'd0);
    chk(-1, "rst_count", 32'(count),     32'd0);
    chk(-1, "rst_empty", 32'(empty),     32'd1);
    chk(-1, "rst_full",  32'(full),      32'd0);
    chk(-1, "rst_valid", 32'(dat_valid), 32'd0);
    chk(-1, "rst_mode",  32'(mode_o),    32'd0);
    chk(-1, "rst_ovf",   32'(ovf),       32'd0);
    chk(-1, "rst_udf",   32'(udf),       32'd0);
    rst_i = 1'b0; mode_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run(i, tbl[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
